oled_stream_driver: RTL

//  Display-side end of the pixel_index/pixel_data interface used by the screen generators and the

---
 rtl/oled_stream_driver.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/oled_stream_driver.sv
// SSD1331 (Pmod OLEDrgb) driver: reset/power-up, 22-byte init, display-on, then continuous RGB565 SPI streaming.
// Define OLED_FRAME_SYNC_EN to add the frame_begin output (pulses when pixel_index returns to 0 in STREAM).
module oled_stream_driver #(
  parameter int CLK_DIV       = 2,
  parameter int RST_CYCLES    = 20,
  parameter int PWR_CYCLES    = 1000,
  parameter int PIXEL_LATENCY = 2,
  parameter int NUM_PIXELS    = 6144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        sample_pixel,
  output logic        ready,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        resn,
  output logic        vccen,
  output logic        pmoden
`ifdef OLED_FRAME_SYNC_EN
  ,
  output logic        frame_begin
`endif
);

  localparam int DLY_MAX = (RST_CYCLES > PWR_CYCLES) ? RST_CYCLES : PWR_CYCLES;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LAT_W   = $clog2(PIXEL_LATENCY + 2);

  localparam logic [2:0] S_RES_LOW  = 3'd0;
  localparam logic [2:0] S_RES_WAIT = 3'd1;
  localparam logic [2:0] S_INIT     = 3'd2;
  localparam logic [2:0] S_VCC_ON   = 3'd3;
  localparam logic [2:0] S_DISP_ON  = 3'd4;
  localparam logic [2:0] S_STREAM   = 3'd5;

  function automatic logic [7:0] init_cmd(input logic [4:0] idx);
    case (idx)
      5'd0:  init_cmd = 8'hAE;
      5'd1:  init_cmd = 8'hA0;
      5'd2:  init_cmd = 8'h72;
      5'd3:  init_cmd = 8'hA1;
      5'd4:  init_cmd = 8'h00;
      5'd5:  init_cmd = 8'hA2;
      5'd6:  init_cmd = 8'h00;
      5'd7:  init_cmd = 8'hA4;
      5'd8:  init_cmd = 8'hA8;
      5'd9:  init_cmd = 8'h3F;
      5'd10: init_cmd = 8'hAD;
      5'd11: init_cmd = 8'h8E;
      5'd12: init_cmd = 8'hB0;
      5'd13: init_cmd = 8'h0B;
      5'd14: init_cmd = 8'h81;
      5'd15: init_cmd = 8'hFF;
      5'd16: init_cmd = 8'h82;
      5'd17: init_cmd = 8'hFF;
      5'd18: init_cmd = 8'h83;
      5'd19: init_cmd = 8'hFF;
      5'd20: init_cmd = 8'h87;
      5'd21: init_cmd = 8'h06;
      default: init_cmd = 8'h00;
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [4:0]       cmd_idx_q, cmd_idx_d;
  logic [15:0]      sr_q, sr_d;
  logic [3:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             tx_busy_q, tx_busy_d;
  logic [15:0]      buf_q, buf_d;
  logic [12:0]      pix_q, pix_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             started_q, started_d;
  logic             frame_q, frame_d;

  logic             tx_done;
  logic             load_en;
  logic [15:0]      load_val;
  logic [3:0]       last_bit;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cmd_idx_d = cmd_idx_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
    tx_busy_d = tx_busy_q;
    buf_d     = buf_q;
    pix_d     = pix_q;
    lat_d     = lat_q;
    started_d = started_q;
    frame_d   = 1'b0;
    tx_done   = 1'b0;
    load_en   = 1'b0;
    load_val  = 16'h0000;
    last_bit  = (state_q == S_STREAM) ? 4'd15 : 4'd7;

    // Bit engine: sclk low half then high half; data moves only as sclk falls.
    if (tx_busy_q) begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else if (bit_q == last_bit) begin
          tx_done   = 1'b1;
          tx_busy_d = 1'b0;
        end else begin
          bit_d  = bit_q + 4'd1;
          sclk_d = 1'b0;
          sr_d   = {sr_q[14:0], 1'b0};
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    case (state_q)
      S_RES_LOW: begin
        if (dly_q == DLY_W'(RST_CYCLES - 1)) begin
          state_d = S_RES_WAIT;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      S_RES_WAIT: begin
        if (dly_q == DLY_W'(RST_CYCLES - 1)) begin
          state_d   = S_INIT;
          dly_d     = '0;
          cmd_idx_d = 5'd0;
          load_en   = 1'b1;
          load_val  = {init_cmd(5'd0), 8'h00};
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      S_INIT: begin
        if (tx_done) begin
          if (cmd_idx_q == 5'd21) begin
            state_d = S_VCC_ON;
            dly_d   = '0;
          end else begin
            cmd_idx_d = cmd_idx_q + 5'd1;
            load_en   = 1'b1;
            load_val  = {init_cmd(cmd_idx_q + 5'd1), 8'h00};
          end
        end
      end
      S_VCC_ON: begin
        if (dly_q == DLY_W'(PWR_CYCLES - 1)) begin
          state_d  = S_DISP_ON;
          dly_d    = '0;
          load_en  = 1'b1;
          load_val = 16'hAF00;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      S_DISP_ON: begin
        if (tx_done) begin
          state_d   = S_STREAM;
          pix_d     = 13'd0;
          lat_d     = '0;
          started_d = 1'b0;
          frame_d   = 1'b1;
        end
      end
      S_STREAM: begin
        if (lat_q != LAT_W'(PIXEL_LATENCY + 1)) lat_d = lat_q + LAT_W'(1);
        if (lat_q == LAT_W'(PIXEL_LATENCY)) buf_d = pixel_data;
        // The buffer always holds the pixel for the word about to start, so word N carries index N.
        if ((!started_q && lat_q == LAT_W'(PIXEL_LATENCY + 1)) || tx_done) begin
          load_en   = 1'b1;
          load_val  = buf_q;
          started_d = 1'b1;
          lat_d     = '0;
          pix_d     = (pix_q == 13'(NUM_PIXELS - 1)) ? 13'd0 : pix_q + 13'd1;
          frame_d   = (pix_q == 13'(NUM_PIXELS - 1));
        end
      end
      default: state_d = S_RES_LOW;
    endcase

    if (load_en) begin
      sr_d      = load_val;
      bit_d     = 4'd0;
      div_d     = '0;
      sclk_d    = 1'b0;
      tx_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RES_LOW;
      dly_q     <= '0;
      cmd_idx_q <= 5'd0;
      sr_q      <= 16'h0000;
      bit_q     <= 4'd0;
      div_q     <= '0;
      sclk_q    <= 1'b1;
      tx_busy_q <= 1'b0;
      buf_q     <= 16'h0000;
      pix_q     <= 13'd0;
      lat_q     <= '0;
      started_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      cmd_idx_q <= cmd_idx_d;
      sr_q      <= sr_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      tx_busy_q <= tx_busy_d;
      buf_q     <= buf_d;
      pix_q     <= pix_d;
      lat_q     <= lat_d;
      started_q <= started_d;
      frame_q   <= frame_d;
    end
  end

  assign pixel_index  = pix_q;
  assign sample_pixel = (state_q == S_STREAM) && (lat_q == LAT_W'(PIXEL_LATENCY));
  assign ready        = (state_q == S_STREAM);
  assign cs           = !((state_q == S_INIT) || (state_q == S_DISP_ON) || (state_q == S_STREAM));
  assign sclk         = sclk_q;
  assign sdin         = sr_q[15];
  assign d_cn         = (state_q == S_STREAM);
  assign resn         = (state_q != S_RES_LOW);
  assign vccen        = (state_q == S_VCC_ON) || (state_q == S_DISP_ON) || (state_q == S_STREAM);
  assign pmoden       = 1'b1;
`ifdef OLED_FRAME_SYNC_EN
  assign frame_begin  = frame_q;
`else
  logic unused_frame;
  assign unused_frame = frame_q;
`endif

endmodule
